// File: rtl/matrix_vec_core.sv
// Matrix-vector multiply core: loads a ROWS x COLS weight matrix, then streams COLS-element
// vectors and emits ROWS results each. Define MATRIX_VEC_SAT_EN for saturating accumulation.
module matrix_vec_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  snk_vld,
  output logic                  snk_rdy,
  input  logic [DATA_WIDTH-1:0] snk_data,
  output logic                  src_vld,
  input  logic                  src_rdy,
  output logic [ACC_WIDTH-1:0]  src_data,
  output logic                  src_last,
  input  logic                  cfg_signed,
  input  logic                  cfg_keep_w,
  output logic                  is_computing
);

  localparam int NW  = ROWS * COLS;
  localparam int WCW = $clog2(NW);
  localparam int XCW = $clog2(COLS);
  localparam int OCW = $clog2(ROWS);
  localparam logic [WCW-1:0] W_LAST = WCW'(NW - 1);
  localparam logic [XCW-1:0] X_LAST = XCW'(COLS - 1);
  localparam logic [OCW-1:0] O_LAST = OCW'(ROWS - 1);
`ifdef MATRIX_VEC_SAT_EN
  localparam int SUM_W = ACC_WIDTH + 1;  // one guard bit to detect overflow before clamping
`else
  localparam int SUM_W = ACC_WIDTH;
`endif

  typedef enum logic [1:0] {S_LOAD_W, S_LOAD_X, S_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [WCW-1:0]       w_cnt_q;
  logic [XCW-1:0]       x_cnt_q;
  logic [OCW-1:0]       out_cnt_q;
  logic                 signed_q, keep_q;
  logic [ACC_WIDTH-1:0] acc_arr [ROWS];

  logic snk_hs, src_hs, w_last, x_last, out_last;
  logic mode_signed, acc_en, acc_clr, w_we;

  assign snk_hs   = snk_vld && snk_rdy;
  assign src_hs   = src_vld && src_rdy;
  assign w_last   = (w_cnt_q == W_LAST);
  assign x_last   = (x_cnt_q == X_LAST);
  assign out_last = (out_cnt_q == O_LAST);

  // The first X byte of a vector already uses the mode being latched alongside it.
  assign mode_signed = (x_cnt_q == '0) ? cfg_signed : signed_q;

  assign w_we    = (state_q == S_LOAD_W) && snk_hs;
  assign acc_en  = (state_q == S_LOAD_X) && snk_hs;
  assign acc_clr = (w_we && w_last) || ((state_q == S_FLUSH) && src_hs && out_last);

  function automatic logic [SUM_W-1:0] ext_op(input logic [DATA_WIDTH-1:0] v, input logic sgn);
    return {{(SUM_W-DATA_WIDTH){sgn & v[DATA_WIDTH-1]}}, v};
  endfunction

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    logic [DATA_WIDTH-1:0] w_row [COLS];
    logic [SUM_W-1:0]      prod;
    logic [ACC_WIDTH-1:0]  acc_q, acc_nxt;

    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam logic [WCW-1:0] W_IDX = WCW'(g * COLS + c);
      logic [DATA_WIDTH-1:0] w_q;
      // NOTE: the weight store is cleared on reset because reset must discard any partial load.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       w_q <= '0;
        else if (w_we && w_cnt_q == W_IDX) w_q <= snk_data;
      end
      assign w_row[c] = w_q;
    end

    // Operands are extended to the sum width first, so the low bits of the product are exact.
    assign prod = ext_op(w_row[x_cnt_q], mode_signed) * ext_op(snk_data, mode_signed);

`ifdef MATRIX_VEC_SAT_EN
    logic [SUM_W-1:0] sum;
    assign sum = {mode_signed & acc_q[ACC_WIDTH-1], acc_q} + prod;
    always_comb begin
      acc_nxt = sum[ACC_WIDTH-1:0];
      if (mode_signed) begin
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
          acc_nxt = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else if (sum[ACC_WIDTH]) begin
        acc_nxt = '1;
      end
    end
`else
    assign acc_nxt = acc_q + prod;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       acc_q <= '0;
      else if (acc_clr) acc_q <= '0;
      else if (acc_en)  acc_q <= acc_nxt;
    end
    assign acc_arr[g] = acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD_W;
      w_cnt_q   <= '0;
      x_cnt_q   <= '0;
      out_cnt_q <= '0;
      signed_q  <= 1'b0;
      keep_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      state_q <= state_d;
      case (state_q)
        S_LOAD_W: if (snk_hs) begin
          w_cnt_q <= w_last ? '0 : w_cnt_q + 1'b1;
          if (w_last) x_cnt_q <= '0;
        end
        S_LOAD_X: if (snk_hs) begin
          if (x_cnt_q == '0) begin
            signed_q <= cfg_signed;
            keep_q   <= cfg_keep_w;
          end
          x_cnt_q <= x_last ? '0 : x_cnt_q + 1'b1;
          if (x_last) out_cnt_q <= '0;
        end
        S_FLUSH: if (src_hs) begin
          out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
          if (out_last && !keep_q) w_cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    snk_rdy  = 1'b0;
    src_vld  = 1'b0;
    src_last = 1'b0;
    src_data = '0;
    case (state_q)
      S_LOAD_W: begin
        snk_rdy = 1'b1;
        if (snk_hs && w_last) state_d = S_LOAD_X;
      end
      S_LOAD_X: begin
        snk_rdy = 1'b1;
        if (snk_hs && x_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        src_vld  = 1'b1;
        src_data = acc_arr[out_cnt_q];
        src_last = out_last;
        if (src_hs && out_last) state_d = keep_q ? S_LOAD_X : S_LOAD_W;
      end
      default: state_d = S_LOAD_W;
    endcase
  end

  assign is_computing = !(((state_q == S_LOAD_W) && (w_cnt_q == '0)) ||
                          ((state_q == S_LOAD_X) && (x_cnt_q == '0)));

endmodule
